leve_wb: RTL and testbench
==========================

LEVE_WB -- requirements
Module: leve_wb

Interface
REQ-001 Parameter DEPTH, default 4, result FIFO entries; power of two, at least 2.
REQ-002 Parameter VLMAX, default 32, maximum elements per vector op; power of two.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, synchronous and active-high.
REQ-005 START  input  1  one-cycle pulse that begins a writeback op.
REQ-006 VD  input  5  destination vector register index, sampled on START.
REQ-007 VL  input  $clog2(VLMAX)+1  element count, sampled on START.
REQ-008 ALU_OUT_VALID  input  1  ALU result valid; no backpressure exists toward the ALU.
REQ-009 ALU_OUT  input  `XLEN  ALU result data.
REQ-010 VRF_WREADY  input  1  register file accepts the write this cycle.
REQ-011 VRF_WE  output  1  write request to the register file.
REQ-012 VRF_WREG  output  5  destination register of the write.
REQ-013 VRF_WIDX  output  $clog2(VLMAX)  element index of the write.
REQ-014 VRF_WDATA  output  `XLEN  write data.
REQ-015 BUSY  output  1  high while the op is active.
REQ-016 DONE  output  1  one-cycle pulse when the op completes.
REQ-017 ERR_OVF  output  1  sticky flag: a result was dropped because the FIFO was full.
REQ-018 ERR_STRAY  output  1  sticky flag: a result arrived while idle.

Function
REQ-019 The FSM SHALL have two states, IDLE and RUN; BUSY = (state==RUN).
REQ-020 In IDLE, START with VL!=0 SHALL latch VD and VL, clear the element index to 0, and enter RUN next cycle.
REQ-021 In IDLE, START with VL==0 SHALL pulse DONE next cycle and stay in IDLE.
REQ-022 START while in RUN SHALL be ignored.
REQ-023 In RUN, ALU_OUT_VALID SHALL push ALU_OUT into the FIFO.
REQ-024 A push when the FIFO is full and no pop occurs that cycle SHALL drop the data and set ERR_OVF; push and pop on a full FIFO in the same cycle SHALL both succeed.
REQ-025 ALU_OUT_VALID in IDLE SHALL drop the data and set ERR_STRAY.
REQ-026 VRF_WE = RUN and FIFO not empty; VRF_WDATA = FIFO head; VRF_WREG = latched VD; VRF_WIDX = element index.
REQ-027 VRF_WE and VRF_WREADY both high SHALL pop the FIFO and increment the element index.
REQ-028 Default latency SHALL be 1 cycle: a result pushed in cycle N is presented on VRF_WE/VRF_WDATA in cycle N+1 at the earliest.
REQ-029 The pop of element VL-1 SHALL return the FSM to IDLE and pulse DONE in the following cycle.
REQ-030 Results beyond VL in the same op SHALL be treated as stray (REQ-025) after the return to IDLE.
REQ-031 The FIFO pointers SHALL wrap modulo DEPTH, and full/empty SHALL be resolved with an extra pointer bit.

Reset
REQ-032 RST SHALL force IDLE, empty the FIFO, clear the element index, and drive VRF_WE, BUSY, DONE, ERR_OVF, ERR_STRAY, VRF_WREG, VRF_WIDX and VRF_WDATA to 0.
REQ-033 RST during RUN SHALL abort the op without a DONE pulse; RST is the only way to clear the sticky flags.

Configuration
REQ-034 Macro LEVE_WB_BYPASS_EN: when defined, in RUN with the FIFO empty, ALU_OUT_VALID SHALL drive VRF_WE/VRF_WDATA in the same cycle.
REQ-035 With LEVE_WB_BYPASS_EN defined and VRF_WREADY high in that cycle, the data SHALL be written and not pushed; otherwise it SHALL be pushed.
REQ-036 Without LEVE_WB_BYPASS_EN, there SHALL be no combinational path from ALU_OUT to the VRF outputs (REQ-028 holds).

Structure
REQ-037 Package leve_pkg SHALL hold the wb_state_t enum (IDLE, RUN) and the default VLMAX and DEPTH constants; XLEN comes from defs.vh.
REQ-038 The FIFO SHALL be the sub-module leve_wb_fifo (push/pop/full/empty/head), instanced once.

Verification
REQ-039 Check the basic op: START VD=3 VL=4, VRF_WREADY=1, results 0x10..0x13 on consecutive cycles -> four writes reg 3 idx 0..3, each 1 cycle after its push; DONE one cycle after the last write; BUSY low after.
REQ-040 Check backpressure: VL=8, VRF_WREADY=0 for 6 cycles while 6 results arrive, DEPTH=4 -> ERR_OVF=1; 4 entries are written in order once ready rises.
REQ-041 Check empty and stray cases: START with VL=0 -> DONE next cycle, BUSY stays 0; then ALU_OUT_VALID in IDLE -> ERR_STRAY=1, no VRF_WE.
REQ-042 Check full with simultaneous push and pop: FIFO full, push and pop in the same cycle -> no ERR_OVF; the data order is preserved across the pointer wrap.
REQ-043 Check reset mid-op: RST in RUN after 2 of 5 writes -> next cycle all outputs 0 and IDLE, no DONE; a fresh START then runs normally from idx 0.
REQ-044 Check the bypass: with LEVE_WB_BYPASS_EN defined, an empty FIFO and VRF_WREADY=1 -> VRF_WE is asserted in the same cycle as ALU_OUT_VALID.

Source files
------------

// File: rtl/leve_pkg.sv
// Shared types and defaults for the leve writeback stage.
// XLEN normally comes from defs.vh; a 32-bit fallback is defined here when it is not already set.
`ifndef XLEN
`define XLEN 32
`endif

package leve_pkg;
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } wb_state_t;

    localparam int DEPTH_DEF = 4;
    localparam int VLMAX_DEF = 32;
endpackage

// File: rtl/leve_wb_fifo.sv
// Result FIFO for the writeback stage: DEPTH entries, wrap-bit pointers, synchronous flush.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
`ifndef XLEN
`define XLEN 32
`endif

module leve_wb_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Same index with differing wrap bits means the writer is a full lap ahead.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/leve_wb.sv
// Vector writeback stage: buffers ALU results and writes them to the register file element by element.
// Optional macro LEVE_WB_BYPASS_EN lets a result reach the register file in its arrival cycle when the FIFO is empty.
`ifndef XLEN
`define XLEN 32
`endif

module leve_wb
    import leve_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int VLMAX = VLMAX_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     START,
    input  logic [4:0]               VD,
    input  logic [$clog2(VLMAX):0]   VL,
    input  logic                     ALU_OUT_VALID,
    input  logic [`XLEN-1:0]         ALU_OUT,
    input  logic                     VRF_WREADY,
    output logic                     VRF_WE,
    output logic [4:0]               VRF_WREG,
    output logic [$clog2(VLMAX)-1:0] VRF_WIDX,
    output logic [`XLEN-1:0]         VRF_WDATA,
    output logic                     BUSY,
    output logic                     DONE,
    output logic                     ERR_OVF,
    output logic                     ERR_STRAY
);
    localparam int IW = $clog2(VLMAX);

    wb_state_t          state;
    logic [4:0]         vd_q;
    logic [IW:0]        vl_q;
    logic [IW-1:0]      idx;
    logic               done_q;
    logic               ovf_q;
    logic               stray_q;

    logic               run;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    logic [`XLEN-1:0]   fifo_head;
    logic               fire;
    logic               last;
    logic               flush;

    assign run      = (state == RUN);
    assign fifo_pop = run && !fifo_empty && VRF_WREADY;

`ifdef LEVE_WB_BYPASS_EN
    logic byp;
    assign byp       = run && fifo_empty && ALU_OUT_VALID;
    assign VRF_WE    = run && (!fifo_empty || ALU_OUT_VALID);
    assign VRF_WDATA = !VRF_WE ? '0 : (!fifo_empty ? fifo_head : ALU_OUT);
    // A bypassed result that the register file takes immediately never enters the FIFO.
    assign fifo_push = run && ALU_OUT_VALID && !(byp && VRF_WREADY);
`else
    assign VRF_WE    = run && !fifo_empty;
    assign VRF_WDATA = VRF_WE ? fifo_head : '0;
    assign fifo_push = run && ALU_OUT_VALID;
`endif

    assign fire  = VRF_WE && VRF_WREADY;
    assign last  = ({1'b0, idx} == (vl_q - (IW+1)'(1)));
    // Results still queued past the final element belong to no op; discard them at completion.
    assign flush = fire && last;

    assign VRF_WREG  = vd_q;
    assign VRF_WIDX  = idx;
    assign BUSY      = run;
    assign DONE      = done_q;
    assign ERR_OVF   = ovf_q;
    assign ERR_STRAY = stray_q;

    leve_wb_fifo #(
        .W     (`XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .flush (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (ALU_OUT),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            vd_q    <= '0;
            vl_q    <= '0;
            idx     <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            stray_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (fifo_push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
            if (ALU_OUT_VALID && !run)               stray_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (START) begin
                        if (VL != '0) begin
                            state <= RUN;
                            vd_q  <= VD;
                            vl_q  <= VL;
                            idx   <= '0;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        idx <= idx + IW'(1);
                        if (last) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_leve_wb.sv
// Self-checking bench for leve_wb: expected register-file writes are queued at stimulus time and matched at output.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
`ifndef XLEN
`define XLEN 32
`endif

module tb_leve_wb;
    localparam int DEPTH = 4;
    localparam int VLMAX = 32;
    localparam int IW    = $clog2(VLMAX);
    localparam int XW    = `XLEN;
    localparam int EW    = 5 + IW + XW;
`ifdef LEVE_WB_BYPASS_EN
    localparam int LAT = 0;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [4:0]    vd;
    logic [IW:0]   vl;
    logic          alu_valid;
    logic [XW-1:0] alu_out;
    logic          ready;
    logic          we;
    logic [4:0]    wreg;
    logic [IW-1:0] widx;
    logic [XW-1:0] wdata;
    logic          busy;
    logic          done;
    logic          err_ovf;
    logic          err_stray;

    always #5 clk = ~clk;

    leve_wb #(
        .DEPTH (DEPTH),
        .VLMAX (VLMAX)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .START         (start),
        .VD            (vd),
        .VL            (vl),
        .ALU_OUT_VALID (alu_valid),
        .ALU_OUT       (alu_out),
        .VRF_WREADY    (ready),
        .VRF_WE        (we),
        .VRF_WREG      (wreg),
        .VRF_WIDX      (widx),
        .VRF_WDATA     (wdata),
        .BUSY          (busy),
        .DONE          (done),
        .ERR_OVF       (err_ovf),
        .ERR_STRAY     (err_stray)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            last_wr_cyc = -1;
    logic [EW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [EW-1:0] mon_e;
    int            mon_c;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every accepted write is matched against the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && we && ready) begin
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(exp_q.size()), 64'd1);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("write", 64'({wreg, widx, wdata}), 64'(mon_e));
                if (mon_c >= 0) check("write_latency", 64'(cyc), 64'(mon_c));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_res(input logic [4:0] r, input int i, input logic [XW-1:0] d, input bit timed);
        alu_valid = 1'b1;
        alu_out   = d;
        exp_q.push_back({r, IW'(i), d});
        exp_cyc_q.push_back(timed ? cyc + LAT : -1);
    endtask

    task automatic start_op(input logic [4:0] r, input int n);
        vd    = r;
        vl    = (IW+1)'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        start     = 1'b0;
        alu_valid = 1'b0;
        ready     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while (exp_q.size() > 0 && n < max) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_done(input string tag, input int max);
        int n = 0;
        @(negedge clk);
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        check(tag, 64'(done), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; vd = '0; vl = '0;
        alu_valid = 1'b0; alu_out = '0; ready = 1'b0;
        tick();
        tick();
        check("rst_we", 64'(we), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_flags", 64'({err_ovf, err_stray}), 64'd0);
        check("rst_wpath", 64'({wreg, widx, wdata}), 64'd0);
        rst = 1'b0;

        // Basic op: four results back to back, register file always ready.
        ready = 1'b1;
        start_op(5'd3, 4);
        check("basic_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) begin
            push_res(5'd3, i, XW'(32'h10 + i), 1'b1);
            tick();
        end
        alu_valid = 1'b0;
        wait_done("basic_done", 10);
        check("basic_done_lat", 64'(cyc), 64'(last_wr_cyc + 1));
        check("basic_busy_at_done", 64'(busy), 64'd0);
        tick();
        check("basic_done_pulse", 64'(done), 64'd0);
        drain("basic_drain", 2);

        // Backpressure: six results into a four-entry FIFO while the register file stalls.
        do_reset();
        start_op(5'd5, 8);
        for (int i = 0; i < 6; i++) begin
            if (i < DEPTH) begin
                push_res(5'd5, i, XW'(32'h20 + i), 1'b0);
            end else begin
                alu_valid = 1'b1;
                alu_out   = XW'(32'h20 + i);
            end
            tick();
        end
        alu_valid = 1'b0;
        check("bp_ovf", 64'(err_ovf), 64'd1);
        check("bp_we_stalled", 64'(we), 64'd1);
        check("bp_busy", 64'(busy), 64'd1);
        ready = 1'b1;
        drain("bp_drain", 10);
        check("bp_ovf_sticky", 64'(err_ovf), 64'd1);
        for (int i = 4; i < 8; i++) begin
            push_res(5'd5, i, XW'(32'h30 + i), 1'b0);
            tick();
        end
        alu_valid = 1'b0;
        wait_done("bp_done", 10);

        // Full FIFO with push and pop together, data order across the pointer wrap.
        do_reset();
        start_op(5'd7, 8);
        for (int i = 0; i < 4; i++) begin
            push_res(5'd7, i, XW'(32'h40 + i), 1'b0);
            tick();
        end
        ready = 1'b1;
        for (int i = 4; i < 8; i++) begin
            push_res(5'd7, i, XW'(32'h40 + i), 1'b0);
            tick();
        end
        alu_valid = 1'b0;
        drain("full_drain", 10);
        check("full_no_ovf", 64'(err_ovf), 64'd0);
        wait_done("full_done", 10);

        // Empty op and a stray result while idle.
        do_reset();
        start_op(5'd1, 0);
        check("empty_done", 64'(done), 64'd1);
        check("empty_busy", 64'(busy), 64'd0);
        tick();
        check("empty_done_pulse", 64'(done), 64'd0);
        alu_valid = 1'b1;
        alu_out   = XW'(32'h99);
        check("stray_before", 64'(err_stray), 64'd0);
        check("stray_no_we", 64'(we), 64'd0);
        tick();
        alu_valid = 1'b0;
        check("stray_flag", 64'(err_stray), 64'd1);
        check("stray_no_we_after", 64'(we), 64'd0);

        // Reset in the middle of an op, then a fresh op from index 0.
        do_reset();
        check("rst_clears_stray", 64'(err_stray), 64'd0);
        ready = 1'b1;
        start_op(5'd9, 5);
        push_res(5'd9, 0, XW'(32'h50), 1'b0);
        tick();
        push_res(5'd9, 1, XW'(32'h51), 1'b0);
        tick();
        alu_valid = 1'b0;
        tick();
        check("mid_two_written", 64'(exp_q.size()), 64'd0);
        check("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_we", 64'(we), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_wpath", 64'({wreg, widx, wdata}), 64'd0);
        tick();
        check("mid_rst_no_done", 64'(done), 64'd0);
        start_op(5'd10, 2);
        push_res(5'd10, 0, XW'(32'h60), 1'b0);
        tick();
        push_res(5'd10, 1, XW'(32'h61), 1'b0);
        tick();
        alu_valid = 1'b0;
        wait_done("fresh_done", 10);

`ifdef LEVE_WB_BYPASS_EN
        // Bypass: with an empty FIFO the result is written in its arrival cycle.
        do_reset();
        ready = 1'b1;
        start_op(5'd2, 1);
        push_res(5'd2, 0, XW'(32'h77), 1'b1);
        #1;
        check("byp_same_cycle_we", 64'(we), 64'd1);
        tick();
        alu_valid = 1'b0;
        wait_done("byp_done", 10);
`endif

        tick();
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
